// File: rtl/btn_event.sv
// Button event generator: turns a debounced active-low button level into
// press / release / long-press / auto-repeat pulses plus a held level.
module btn_event #(
  parameter int LONG_CNT   = 25000000,
  parameter int REPEAT_CNT = 5000000,
  parameter int CNT_W      = 26
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iBtn_n,
  input  logic       iEn,
  output logic       oPress,
  output logic       oRelease,
  output logic       oLong,
  output logic       oRepeat,
  output logic       oHeld,
  output logic [1:0] oState
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHORT = 2'd1;
  localparam logic [1:0] LONG  = 2'd2;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  logic             btn_q;
  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             press_d, release_d, long_d, repeat_d, held_d;

  // Handshake-free block: pulses are single-cycle strobes with no ready;
  // consumers must sample every cycle.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    if (!iEn) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_d = '0;
          if (!btn_q) begin
            state_d = SHORT;
            press_d = 1'b1;
          end
        end
        SHORT: begin
          if (btn_q) begin
            // Release wins over a coincident terminal count.
            state_d   = IDLE;
            release_d = 1'b1;
            cnt_d     = '0;
          end else if (cnt == LONG_LAST) begin
            state_d = LONG;
            long_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        LONG: begin
          if (btn_q) begin
            state_d   = IDLE;
            release_d = 1'b1;
            cnt_d     = '0;
          end else if (cnt == REPEAT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    held_d = (state_d == SHORT) || (state_d == LONG);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      btn_q    <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      oPress   <= 1'b0;
      oRelease <= 1'b0;
      oLong    <= 1'b0;
      oRepeat  <= 1'b0;
      oHeld    <= 1'b0;
    end else begin
      btn_q    <= iBtn_n;
      state    <= state_d;
      cnt      <= cnt_d;
      oPress   <= press_d;
      oRelease <= release_d;
      oLong    <= long_d;
      oRepeat  <= repeat_d;
      oHeld    <= held_d;
    end
  end

  assign oState = state;

endmodule

// File: tb/tb_btn_event.sv
// Self-checking bench for btn_event: directed scenarios plus random button
// activity, compared cycle by cycle against a hold-age reference model.
module tb_btn_event;

  localparam int LONG_CNT   = 8;
  localparam int REPEAT_CNT = 4;

  logic       iClk;
  logic       iRst_n;
  logic       iBtn_n;
  logic       iEn;
  logic       oPress, oRelease, oLong, oRepeat, oHeld;
  logic [1:0] oState;

  int checks;
  int errors;

  logic [6:0] exp_q[$];

  // Reference model: press age in edges since the press event.
  logic m_bq;
  bit   m_held;
  int   m_age;

  // Observed pulse tallies for directed scenarios.
  int n_press, n_release, n_long, n_repeat, n_held;

  btn_event #(
    .LONG_CNT  (LONG_CNT),
    .REPEAT_CNT(REPEAT_CNT),
    .CNT_W     (8)
  ) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iBtn_n  (iBtn_n),
    .iEn     (iEn),
    .oPress  (oPress),
    .oRelease(oRelease),
    .oLong   (oLong),
    .oRepeat (oRepeat),
    .oHeld   (oHeld),
    .oState  (oState)
  );

  // Clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_vec();
    return {oPress, oRelease, oLong, oRepeat, oHeld, oState};
  endfunction

  task automatic model_reset();
    m_bq   = 1'b1;
    m_held = 1'b0;
    m_age  = 0;
  endtask

  task automatic model_edge(input logic btn, input logic en, output logic [6:0] e);
    logic p, r, l, rp;
    logic [1:0] st;
    p = 1'b0; r = 1'b0; l = 1'b0; rp = 1'b0;
    if (!en) begin
      m_held = 1'b0;
    end else if (!m_held) begin
      if (!m_bq) begin
        p      = 1'b1;
        m_held = 1'b1;
        m_age  = 0;
      end
    end else begin
      m_age++;
      if (m_bq) begin
        r      = 1'b1;
        m_held = 1'b0;
      end else if (m_age == LONG_CNT) begin
        l = 1'b1;
      end else if (m_age > LONG_CNT && ((m_age - LONG_CNT) % REPEAT_CNT) == 0) begin
        rp = 1'b1;
      end
    end
    m_bq = btn;
    st = !m_held ? 2'd0 : (m_age >= LONG_CNT ? 2'd2 : 2'd1);
    e = {p, r, l, rp, m_held, st};
  endtask

  // Driver: apply inputs for one clock, update model, check at negedge.
  task automatic step(input logic btn, input logic en);
    logic [6:0] e;
    logic [6:0] got;
    iBtn_n = btn;
    iEn    = en;
    @(posedge iClk);
    model_edge(btn, en, e);
    exp_q.push_back(e);
    @(negedge iClk);
    got = dut_vec();
    check_eq("outs", {25'd0, got}, {25'd0, exp_q.pop_front()});
    check_eq("onehot", {31'd0, $onehot0({oPress, oRelease, oLong, oRepeat})}, 32'd1);
    n_press   += int'(oPress);
    n_release += int'(oRelease);
    n_long    += int'(oLong);
    n_repeat  += int'(oRepeat);
    n_held    += int'(oHeld);
  endtask

  task automatic clear_tally();
    n_press = 0; n_release = 0; n_long = 0; n_repeat = 0; n_held = 0;
  endtask

  // Assert reset at a negedge and confirm outputs clear without a clock edge.
  task automatic pulse_reset(input int cycles);
    @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check_eq("rst_outs", {25'd0, dut_vec()}, 32'd0);
    model_reset();
    exp_q.delete();
    repeat (cycles) @(negedge iClk);
    check_eq("rst_hold", {25'd0, dut_vec()}, 32'd0);
    iRst_n = 1'b1;
  endtask

  initial begin
    int run;
    logic btn;
    checks = 0;
    errors = 0;
    iRst_n = 1'b0;
    iBtn_n = 1'b1;
    iEn    = 1'b1;
    model_reset();
    clear_tally();
    #1;
    check_eq("por_outs", {25'd0, dut_vec()}, 32'd0);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    repeat (3) step(1'b1, 1'b1);

    // Short press: 5 cycles low.
    clear_tally();
    repeat (5) step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b1);
    check_eq("short_press_n", n_press, 1);
    check_eq("short_release_n", n_release, 1);
    check_eq("short_long_n", n_long, 0);
    check_eq("short_held_n", n_held, 5);

    // Long hold with auto-repeat.
    clear_tally();
    repeat (30) step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b1);
    check_eq("long_press_n", n_press, 1);
    check_eq("long_long_n", n_long, 1);
    check_eq("long_release_n", n_release, 1);

    // Release coinciding with the long terminal count.
    clear_tally();
    repeat (LONG_CNT) step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b1);
    check_eq("edge_long_n", n_long, 0);
    check_eq("edge_release_n", n_release, 1);
    check_eq("edge_state", oState, 0);

    // Reset mid-hold in LONG, button still held afterwards.
    repeat (12) step(1'b0, 1'b1);
    check_eq("pre_rst_state", oState, 2);
    pulse_reset(2);
    clear_tally();
    repeat (3) step(1'b0, 1'b1);
    check_eq("post_rst_release_n", n_release, 0);
    check_eq("post_rst_press_n", n_press, 1);
    repeat (4) step(1'b1, 1'b1);

    // Enable dropout during LONG.
    repeat (12) step(1'b0, 1'b1);
    clear_tally();
    repeat (3) step(1'b0, 1'b0);
    check_eq("en_off_pulses", n_press + n_release + n_long + n_repeat, 0);
    check_eq("en_off_state", oState, 0);
    repeat (10) step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b1);

    // Random activity.
    btn = 1'b1;
    run = 3;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        btn = ~btn;
        run = btn ? $urandom_range(1, 6) : $urandom_range(1, 40);
      end
      run--;
      if ($urandom_range(0, 399) == 0) pulse_reset($urandom_range(1, 3));
      step(btn, $urandom_range(0, 49) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
